// File: rtl/rsa_op_sequencer.sv
// Front-panel sequencer: debounced buttons -> one-cycle engine starts.
// Ports: clk/rst, buttons[2:0] (active low), *_done in, *_start/busy/flags/state out.
module rsa_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] buttons,
  input  logic       gen_done,
  input  logic       enc_done,
  input  logic       dec_done,
  output logic       gen_start,
  output logic       enc_start,
  output logic       dec_start,
  output logic       busy,
  output logic       key_valid,
  output logic       ct_valid,
  output logic       err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GEN_WAIT = 2'd1,
    ENC_WAIT = 2'd2,
    DEC_WAIT = 2'd3
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    db;
  logic [2:0]    db_q;
  logic [2:0]    arm;
  logic [DW-1:0] cnt [3];

  // arm[i] only sets once the button is seen released, so a button
  // held through reset cannot fire until it is released and re-pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      db   <= 3'b111;
      db_q <= 3'b111;
      arm  <= 3'b000;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < 3; i++) begin
        if (buttons[i] != db[i]) begin
          if (cnt[i] == DLAST) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
        if (db[i] && buttons[i]) arm[i] <= 1'b1;
      end
    end
  end

  logic [2:0] fall;
  logic       one_low;
  logic [2:0] cmd;

  assign fall    = db_q & ~db & arm;
  assign one_low = (db == 3'b110) || (db == 3'b101) || (db == 3'b011);
  assign cmd     = one_low ? fall : 3'b000;

  state_t        st, st_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          kv_n, ct_n, err_n;
  logic          gs_n, es_n, ds_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      wcnt      <= '0;
      key_valid <= 1'b0;
      ct_valid  <= 1'b0;
      err       <= 1'b0;
      gen_start <= 1'b0;
      enc_start <= 1'b0;
      dec_start <= 1'b0;
    end else begin
      st        <= st_n;
      wcnt      <= wcnt_n;
      key_valid <= kv_n;
      ct_valid  <= ct_n;
      err       <= err_n;
      gen_start <= gs_n;
      enc_start <= es_n;
      dec_start <= ds_n;
    end
  end

  always_comb begin
    st_n   = st;
    wcnt_n = wcnt + 1'b1;
    kv_n   = key_valid;
    ct_n   = ct_valid;
    err_n  = err;
    gs_n   = 1'b0;
    es_n   = 1'b0;
    ds_n   = 1'b0;
    unique case (st)
      IDLE: begin
        wcnt_n = '0;
        unique case (1'b1)
          cmd[0]: begin
            gs_n  = 1'b1;
            kv_n  = 1'b0;
            ct_n  = 1'b0;
            err_n = 1'b0;
            st_n  = GEN_WAIT;
          end
          cmd[1]: begin
            if (key_valid) begin
              es_n  = 1'b1;
              err_n = 1'b0;
              st_n  = ENC_WAIT;
            end else begin
              err_n = 1'b1;
            end
          end
          cmd[2]: begin
            if (ct_valid) begin
              ds_n  = 1'b1;
              err_n = 1'b0;
              st_n  = DEC_WAIT;
            end else begin
              err_n = 1'b1;
            end
          end
          default: ;
        endcase
      end
      GEN_WAIT: begin
        if (gen_done) begin
          kv_n = 1'b1;
          st_n = IDLE;
        end else if (wcnt == WLAST) begin
          err_n = 1'b1;
          st_n  = IDLE;
        end
      end
      ENC_WAIT: begin
        if (enc_done) begin
          ct_n = 1'b1;
          st_n = IDLE;
        end else if (wcnt == WLAST) begin
          err_n = 1'b1;
          st_n  = IDLE;
        end
      end
      DEC_WAIT: begin
        if (dec_done) begin
          st_n = IDLE;
        end else if (wcnt == WLAST) begin
          err_n = 1'b1;
          st_n  = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  assign busy  = (st != IDLE);
  assign state = st;

endmodule

// File: tb/tb_rsa_op_sequencer.sv
// Directed bench for rsa_op_sequencer (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8).
// Start pulses are counted on the falling edge; checks run #1 after posedge.
module tb_rsa_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] buttons;
  logic       gen_done, enc_done, dec_done;
  logic       gen_start, enc_start, dec_start;
  logic       busy, key_valid, ct_valid, err;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int pg = 0, pe = 0, pd = 0;
  int overlap = 0;
  logic [2:0] prev_st = 3'b000;

  rsa_op_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .buttons(buttons),
    .gen_done(gen_done),
    .enc_done(enc_done),
    .dec_done(dec_done),
    .gen_start(gen_start),
    .enc_start(enc_start),
    .dec_start(dec_start),
    .busy(busy),
    .key_valid(key_valid),
    .ct_valid(ct_valid),
    .err(err),
    .state(state)
  );

  always #5 clk = ~clk;

  // Pulse accounting: counts, and any overlap or >1-cycle pulse.
  always @(negedge clk) begin
    logic [2:0] sv;
    sv = {dec_start, enc_start, gen_start};
    if (gen_start) pg++;
    if (enc_start) pe++;
    if (dec_start) pd++;
    if ($countones(sv) > 1) overlap++;
    if ((sv & prev_st) != 3'b000) overlap++;
    prev_st = sv;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    buttons = 3'b111;
    gen_done = 1'b0;
    enc_done = 1'b0;
    dec_done = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if ({gen_start, enc_start, dec_start} !== 3'b000) begin errors++; $display("FAIL reset_starts got %b want 000", {gen_start, enc_start, dec_start}); end
    checks++; if ({busy, key_valid, ct_valid, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy, key_valid, ct_valid, err}); end
  endtask

  task automatic test_sequence();
    logic [2:0] btn [3];
    int p0 [3];
    btn[0] = 3'b110;
    btn[1] = 3'b101;
    btn[2] = 3'b011;
    for (int k = 0; k < 3; k++) begin
      p0[0] = pg; p0[1] = pe; p0[2] = pd;
      buttons = btn[k];
      tick(5);
      checks++; if ({dec_start, enc_start, gen_start} !== (3'b001 << k)) begin errors++; $display("FAIL seq_start[%0d] got %b want %b", k, {dec_start, enc_start, gen_start}, 3'b001 << k); end
      checks++; if (busy !== 1'b1 || state !== 2'(k + 1)) begin errors++; $display("FAIL seq_busy[%0d] got busy=%b state=%0d want 1/%0d", k, busy, state, k + 1); end
      tick(1);
      checks++; if ({dec_start, enc_start, gen_start} !== 3'b000) begin errors++; $display("FAIL seq_width[%0d] got %b want 000", k, {dec_start, enc_start, gen_start}); end
      tick(1);
      {dec_done, enc_done, gen_done} = 3'b001 << k;
      tick(1);
      {dec_done, enc_done, gen_done} = 3'b000;
      checks++; if (state !== 2'd0 || key_valid !== 1'b1) begin errors++; $display("FAIL seq_done[%0d] got state=%0d kv=%b want 0/1", k, state, key_valid); end
      checks++; if (ct_valid !== (k >= 1)) begin errors++; $display("FAIL seq_ct[%0d] got %b want %b", k, ct_valid, k >= 1); end
      tick(2);
      buttons = 3'b111;
      tick(8);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL seq_err[%0d] got %b want 0", k, err); end
      checks++; if ((pg - p0[0]) + (pe - p0[1]) + (pd - p0[2]) !== 1) begin errors++; $display("FAIL seq_pulses[%0d] got %0d want 1", k, (pg - p0[0]) + (pe - p0[1]) + (pd - p0[2])); end
    end
  endtask

  task automatic test_illegal();
    int e0, d0;
    do_reset();
    e0 = pe; d0 = pd;
    buttons = 3'b101;
    tick(5);
    buttons = 3'b111;
    checks++; if (state !== 2'd0 || err !== 1'b1) begin errors++; $display("FAIL ill_enc got state=%0d err=%b want 0/1", state, err); end
    tick(8);
    buttons = 3'b011;
    tick(5);
    buttons = 3'b111;
    checks++; if (state !== 2'd0 || err !== 1'b1) begin errors++; $display("FAIL ill_dec got state=%0d err=%b want 0/1", state, err); end
    checks++; if (pe !== e0 || pd !== d0) begin errors++; $display("FAIL ill_pulses got enc=%0d dec=%0d want 0/0", pe - e0, pd - d0); end
    tick(8);
    buttons = 3'b110;
    tick(5);
    buttons = 3'b111;
    checks++; if (gen_start !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ill_gen got gs=%b err=%b want 1/0", gen_start, err); end
    gen_done = 1'b1;
    tick(1);
    gen_done = 1'b0;
    tick(8);
  endtask

  task automatic test_bounce();
    int n0;
    n0 = pg + pe + pd;
    for (int i = 0; i < 5; i++) begin
      buttons = 3'b110;
      tick(2);
      buttons = 3'b111;
      tick(2);
    end
    tick(4);
    checks++; if (pg + pe + pd !== n0 || state !== 2'd0) begin errors++; $display("FAIL bounce got pulses=%0d state=%0d want 0/0", pg + pe + pd - n0, state); end
    buttons = 3'b100;
    tick(10);
    checks++; if (pg + pe + pd !== n0 || state !== 2'd0) begin errors++; $display("FAIL multi got pulses=%0d state=%0d want 0/0", pg + pe + pd - n0, state); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL multi_err got %b want 0", err); end
    buttons = 3'b111;
    tick(8);
  endtask

  task automatic test_timeout();
    do_reset();
    buttons = 3'b110;
    tick(5);
    buttons = 3'b111;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL to_enter got %0d want 1", state); end
    tick(7);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL to_early got %0d want 1", state); end
    tick(1);
    checks++; if (state !== 2'd0 || err !== 1'b1 || key_valid !== 1'b0) begin errors++; $display("FAIL to_expire got st=%0d err=%b kv=%b want 0/1/0", state, err, key_valid); end
    tick(4);
    buttons = 3'b110;
    tick(5);
    buttons = 3'b111;
    checks++; if (state !== 2'd1 || err !== 1'b0) begin errors++; $display("FAIL to_reenter got st=%0d err=%b want 1/0", state, err); end
    tick(7);
    gen_done = 1'b1;
    tick(1);
    gen_done = 1'b0;
    checks++; if (state !== 2'd0 || err !== 1'b0 || key_valid !== 1'b1) begin errors++; $display("FAIL to_tie got st=%0d err=%b kv=%b want 0/0/1", state, err, key_valid); end
    tick(4);
  endtask

  task automatic test_lockout();
    int g0;
    g0 = pg;
    buttons = 3'b101;
    tick(5);
    checks++; if (enc_start !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL lock_enc got es=%b st=%0d want 1/2", enc_start, state); end
    buttons = 3'b110;
    dec_done = 1'b1;
    tick(1);
    dec_done = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL lock_stray got %0d want 2", state); end
    tick(5);
    checks++; if (state !== 2'd2 || pg !== g0) begin errors++; $display("FAIL lock_gen got st=%0d gen=%0d want 2/0", state, pg - g0); end
    enc_done = 1'b1;
    tick(1);
    enc_done = 1'b0;
    checks++; if (state !== 2'd0 || ct_valid !== 1'b1) begin errors++; $display("FAIL lock_done got st=%0d ct=%b want 0/1", state, ct_valid); end
    tick(10);
    checks++; if (state !== 2'd0 || pg !== g0) begin errors++; $display("FAIL lock_held got st=%0d gen=%0d want 0/0", state, pg - g0); end
    buttons = 3'b111;
    tick(8);
  endtask

  task automatic test_midreset();
    int d0, g0;
    d0 = pd;
    buttons = 3'b011;
    tick(5);
    buttons = 3'b111;
    checks++; if (dec_start !== 1'b1 || state !== 2'd3) begin errors++; $display("FAIL mr_dec got ds=%b st=%0d want 1/3", dec_start, state); end
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (state !== 2'd0 || {gen_start, enc_start, dec_start} !== 3'b000) begin errors++; $display("FAIL mr_state got st=%0d starts=%b want 0/000", state, {gen_start, enc_start, dec_start}); end
    checks++; if ({busy, key_valid, ct_valid, err} !== 4'b0000) begin errors++; $display("FAIL mr_flags got %b want 0000", {busy, key_valid, ct_valid, err}); end
    tick(6);
    buttons = 3'b011;
    tick(5);
    buttons = 3'b111;
    checks++; if (err !== 1'b1 || state !== 2'd0 || pd - d0 !== 1) begin errors++; $display("FAIL mr_after got err=%b st=%0d dec=%0d want 1/0/1", err, state, pd - d0); end
    tick(8);
    g0 = pg;
    buttons = 3'b110;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);
    checks++; if (state !== 2'd0 || pg !== g0) begin errors++; $display("FAIL mr_held got st=%0d gen=%0d want 0/0", state, pg - g0); end
    buttons = 3'b111;
    tick(6);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_illegal();
    test_bounce();
    test_timeout();
    test_lockout();
    test_midreset();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL pulse_shape got %0d want 0", overlap); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
